// File: rtl/prewish_blinky_seq_if.sv
// Host write port of the blinky pattern sequencer: a minimal
// wishbone-style single-beat write with a one-cycle acknowledge.
interface prewish_blinky_seq_if #(
   parameter int ADDR_BITS = 2
);
   logic                 STB_I;
   logic [ADDR_BITS-1:0] ADR_I;
   logic [7:0]           DAT_I;
   logic                 ACK_O;

   modport master (
      output STB_I,
      output ADR_I,
      output DAT_I,
      input  ACK_O
   );

   modport slave (
      input  STB_I,
      input  ADR_I,
      input  DAT_I,
      output ACK_O
   );
endinterface

// File: rtl/prewish_blinky_seq.sv
// Pattern sequencer for one prewish_blinky instance. A host fills a small
// table of LED masks; while running, the entries 0..last are loaded into
// the blinky one at a time with a fixed dwell between loads.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | blinky held in reset, waiting for i_run
// LOAD  | one-cycle load strobe carrying table[index]
// DWELL | counting down the dwell time before the next entry
module prewish_blinky_seq #(
   parameter int NUM_ENTRIES  = 4,
   parameter int ADDR_BITS    = 2,
   parameter int DWELL_BITS   = 27,
   parameter int DWELL_CYCLES = 2**26
) (
   input  logic                 CLK_I,
   input  logic                 RST_N_I,
   prewish_blinky_seq_if.slave  wb,
   input  logic                 i_run,
   input  logic [ADDR_BITS-1:0] i_last,
   output logic                 o_blk_stb,
   output logic [7:0]           o_blk_dat,
   output logic                 o_blk_rst,
   output logic [ADDR_BITS-1:0] o_index,
   output logic                 o_busy
);

   localparam logic [DWELL_BITS-1:0] DWELL_LOAD = DWELL_BITS'(DWELL_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DWELL = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_BITS-1:0]  index_q, index_d;
   logic [ADDR_BITS-1:0]  last_q, last_d;
   logic [DWELL_BITS-1:0] cnt_q, cnt_d;
   logic                  blk_stb_q, blk_stb_d;
   logic [7:0]            blk_dat_q, blk_dat_d;
   logic                  blk_rst_q, blk_rst_d;
   logic                  busy_q, busy_d;
   logic                  ack_q;
   logic [7:0]            table_q [NUM_ENTRIES];
   logic                  wr_en;
   logic                  load_en;

   assign wr_en = wb.STB_I & ~ack_q;

   // Mask table and write acknowledge; a held strobe writes every other cycle.
   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         ack_q <= 1'b0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            table_q[i] <= 8'h00;
         end
      end else begin
         ack_q <= wr_en;
         if (wr_en) begin
            table_q[wb.ADR_I] <= wb.DAT_I;
         end
      end
   end

   assign wb.ACK_O = ack_q;

   // Sequencer state and registered outputs.
   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         state_q   <= IDLE;
         index_q   <= '0;
         last_q    <= '0;
         cnt_q     <= '0;
         blk_stb_q <= 1'b0;
         blk_dat_q <= 8'h00;
         blk_rst_q <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         blk_stb_q <= blk_stb_d;
         blk_dat_q <= blk_dat_d;
         blk_rst_q <= blk_rst_d;
         busy_q    <= busy_d;
      end
   end

   // Next-state and next-output logic; outputs are computed for the state being entered.
   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      blk_stb_d = 1'b0;
      blk_dat_d = blk_dat_q;
      blk_rst_d = blk_rst_q;
      load_en   = 1'b0;

      case (state_q)
         IDLE: begin
            blk_rst_d = 1'b1;
            index_d   = '0;
            cnt_d     = '0;
            if (i_run) begin
               state_d   = LOAD;
               last_d    = i_last;
               blk_rst_d = 1'b0;
               load_en   = 1'b1;
            end
         end
         LOAD: begin
            if (!i_run) begin
               state_d   = IDLE;
               index_d   = '0;
               cnt_d     = '0;
               blk_rst_d = 1'b1;
            end else begin
               state_d = DWELL;
               cnt_d   = DWELL_LOAD;
            end
         end
         DWELL: begin
            if (!i_run) begin
               state_d   = IDLE;
               index_d   = '0;
               cnt_d     = '0;
               blk_rst_d = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = LOAD;
               load_en = 1'b1;
               if (index_q == last_q) begin
                  index_d = '0;
                  last_d  = i_last;
               end else begin
                  index_d = index_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            index_d   = '0;
            cnt_d     = '0;
            blk_rst_d = 1'b1;
         end
      endcase

      // A write landing on the same edge as the load is forwarded so the
      // blinky sees the freshly written mask.
      if (load_en) begin
         blk_stb_d = 1'b1;
         if (wr_en && (wb.ADR_I == index_d)) begin
            blk_dat_d = wb.DAT_I;
         end else begin
            blk_dat_d = table_q[index_d];
         end
      end

      busy_d = (state_d != IDLE);
   end

   assign o_blk_stb = blk_stb_q;
   assign o_blk_dat = blk_dat_q;
   assign o_blk_rst = blk_rst_q;
   assign o_index   = index_q;
   assign o_busy    = busy_q;

endmodule

// File: tb/tb_prewish_blinky_seq.sv
// Bench for the blinky pattern sequencer: directed scenarios followed by
// random traffic, all checked cycle by cycle against a reference model.
module tb_prewish_blinky_seq;

   localparam int AB = 2;
   localparam int NE = 4;
   localparam int DC = 4;
   localparam int PERIOD = DC + 1;

   logic          clk;
   logic          rst_n;
   logic          stb;
   logic [AB-1:0] adr;
   logic [7:0]    dat;
   logic          run;
   logic [AB-1:0] last;

   logic          blk_stb;
   logic [7:0]    blk_dat;
   logic          blk_rst;
   logic [AB-1:0] index;
   logic          busy;

   int checks;
   int errors;

   // reference model
   logic [7:0]    m_tab [NE];
   logic          m_ack;
   logic          m_busy;
   logic          m_stb;
   logic [7:0]    m_dat;
   logic [AB-1:0] m_idx;
   logic [AB-1:0] m_last;
   int            m_t;

   prewish_blinky_seq_if #(.ADDR_BITS(AB)) bus ();

   assign bus.STB_I = stb;
   assign bus.ADR_I = adr;
   assign bus.DAT_I = dat;

   prewish_blinky_seq #(
      .NUM_ENTRIES (NE),
      .ADDR_BITS   (AB),
      .DWELL_BITS  (8),
      .DWELL_CYCLES(DC)
   ) dut (
      .CLK_I    (clk),
      .RST_N_I  (rst_n),
      .wb       (bus.slave),
      .i_run    (run),
      .i_last   (last),
      .o_blk_stb(blk_stb),
      .o_blk_dat(blk_dat),
      .o_blk_rst(blk_rst),
      .o_index  (index),
      .o_busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("ack",     32'(bus.ACK_O), 32'(m_ack));
      chk("blk_stb", 32'(blk_stb),   32'(m_stb));
      chk("blk_dat", 32'(blk_dat),   32'(m_dat));
      chk("blk_rst", 32'(blk_rst),   32'(!m_busy));
      chk("index",   32'(index),     32'(m_idx));
      chk("busy",    32'(busy),      32'(m_busy));
   endtask

   task automatic model_reset();
      for (int i = 0; i < NE; i++) m_tab[i] = 8'h00;
      m_ack  = 1'b0;
      m_busy = 1'b0;
      m_stb  = 1'b0;
      m_dat  = 8'h00;
      m_idx  = '0;
      m_last = '0;
      m_t    = 0;
   endtask

   // One clock: the model consumes the inputs present at the edge, then
   // outputs are compared 1 time unit later.
   task automatic tick();
      logic wr;
      @(posedge clk);
      wr = stb && !m_ack;
      if (wr) m_tab[adr] = dat;
      m_ack = wr;
      m_stb = 1'b0;
      if (!m_busy) begin
         m_idx = '0;
         if (run) begin
            m_busy = 1'b1;
            m_t    = 0;
            m_last = last;
            m_stb  = 1'b1;
            m_dat  = m_tab[0];
         end
      end else if (!run) begin
         m_busy = 1'b0;
         m_idx  = '0;
      end else begin
         m_t++;
         if (m_t % PERIOD == 0) begin
            if (m_idx == m_last) begin
               m_idx  = '0;
               m_last = last;
            end else begin
               m_idx = m_idx + 1'b1;
            end
            m_stb = 1'b1;
            m_dat = m_tab[m_idx];
         end
      end
      #1;
      chk_all();
   endtask

   logic [7:0] wvals [4];
   int acks;
   int guard;

   initial begin
      checks = 0;
      errors = 0;
      wvals[0] = 8'hA5; wvals[1] = 8'h0F; wvals[2] = 8'h81; wvals[3] = 8'hFF;
      rst_n = 1'b0;
      stb = 1'b0; adr = '0; dat = 8'h00; run = 1'b0; last = '0;
      model_reset();
      #12;
      chk_all();
      rst_n = 1'b1;

      // 1: writes with the strobe held high
      stb  = 1'b1;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         adr = AB'(i);
         dat = wvals[i];
         tick(); if (bus.ACK_O) acks++;
         tick(); if (bus.ACK_O) acks++;
      end
      stb = 1'b0;
      tick(); if (bus.ACK_O) acks++;
      chk("ack_count", 32'(acks), 32'd4);

      // 2: sequence over entries 0..2
      last = 2'd2;
      run  = 1'b1;
      tick();
      chk("first_load_dat", 32'(blk_dat), 32'hA5);
      chk("first_load_stb", 32'(blk_stb), 32'd1);
      for (int i = 0; i < 2 * PERIOD; i++) tick();

      // 3: widen the range while entry 1 is presented; applies at the wrap
      guard = 0;
      while (!(m_idx == 2'd1 && !m_stb) && guard < 50) begin tick(); guard++; end
      chk("wait_entry1", 32'(guard < 50), 32'd1);
      last = 2'd3;
      for (int i = 0; i < 6 * PERIOD; i++) tick();

      // 4: drop run mid-dwell, then restart
      guard = 0;
      while (!(m_busy && !m_stb && m_t % PERIOD == 2) && guard < 50) begin tick(); guard++; end
      chk("wait_dwell", 32'(guard < 50), 32'd1);
      run = 1'b0;
      tick();
      chk("stop_rst", 32'(blk_rst), 32'd1);
      run = 1'b1;
      tick();
      chk("restart_dat", 32'(blk_dat), 32'hA5);
      for (int i = 0; i < PERIOD; i++) tick();

      // 5: rewrite the entry being presented
      guard = 0;
      while (!(m_busy && !m_stb) && guard < 50) begin tick(); guard++; end
      stb = 1'b1;
      adr = m_idx;
      dat = 8'h3C;
      tick();
      stb = 1'b0;
      for (int i = 0; i < 5 * PERIOD; i++) tick();

      // 6: asynchronous reset while in LOAD
      guard = 0;
      while (!m_stb && guard < 50) begin tick(); guard++; end
      chk("wait_load", 32'(guard < 50), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_all();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      last = 2'd3;
      for (int i = 0; i < 5 * PERIOD; i++) tick();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         stb = ($urandom_range(0, 2) == 0);
         adr = AB'($urandom_range(0, NE - 1));
         dat = 8'($urandom);
         if ($urandom_range(0, 39) == 0) run = ~run;
         if ($urandom_range(0, 19) == 0) last = AB'($urandom_range(0, NE - 1));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
